// File: rtl/fft_frame_buffer.sv
// rtl/fft_frame_buffer.sv - ping-pong complex frame buffer with natural or bit-reversed replay
module fft_frame_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_STEP   = 9
) (
    input  logic                  iclk,
    input  logic                  rstn,
    input  logic [3:0]            cfg_step,
    input  logic                  cfg_bitrev,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_real,
    input  logic [DATA_WIDTH-1:0] s_imag,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_real,
    output logic [DATA_WIDTH-1:0] m_imag,
    output logic                  m_last,
    output logic [MAX_STEP-1:0]   m_index
);

    localparam int         DEPTH      = 1 << MAX_STEP;
    localparam logic [3:0] MAX_STEP_L = 4'(MAX_STEP);

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    bank_state_t bank_state      [2];
    bank_state_t bank_state_next [2];
    logic [3:0]  tag_step        [2];
    logic        tag_bitrev      [2];

    logic                  wr_bank;
    logic [MAX_STEP-1:0]   wr_cnt;
    logic                  rd_bank;
    logic                  rd_done;
    logic [MAX_STEP-1:0]   rd_cnt;

    logic [2*DATA_WIDTH-1:0] mem [DEPTH*2];
    logic [2*DATA_WIDTH-1:0] ram_q;
    logic                    p1_valid;
    logic                    p1_last;
    logic [MAX_STEP-1:0]     p1_index;

    logic                wr_hs, wr_last, s_ready_next;
    logic [3:0]          cfg_eff;
    logic                m_last_hs, rd_sel, rd_done_cur;
    logic [MAX_STEP-1:0] rd_cnt_cur, rd_mask, rd_addr;
    logic                out_adv, p1_accept, issue, issue_last;

    function automatic logic [3:0] clamp_step(input logic [3:0] s);
        if (s == 4'd0)
            return 4'd1;
        if (s > MAX_STEP_L)
            return MAX_STEP_L;
        return s;
    endfunction

    function automatic logic [MAX_STEP-1:0] step_mask(input logic [3:0] s);
        return ~({MAX_STEP{1'b1}} << s);
    endfunction

    function automatic logic [MAX_STEP-1:0] rev_full(input logic [MAX_STEP-1:0] a);
        logic [MAX_STEP-1:0] r;
        for (int i = 0; i < MAX_STEP; i++)
            r[i] = a[MAX_STEP-1-i];
        return r;
    endfunction

    always_comb begin
        wr_hs   = s_valid & s_ready;
        cfg_eff = clamp_step(cfg_step);
        wr_last = (bank_state[wr_bank] == BANK_FILLING) &&
                  (wr_cnt == step_mask(tag_step[wr_bank]));

        // Retiring a frame hands the read port to the other bank in the same cycle
        m_last_hs   = m_valid & m_ready & m_last;
        rd_sel      = rd_bank ^ m_last_hs;
        rd_cnt_cur  = m_last_hs ? '0 : rd_cnt;
        rd_done_cur = m_last_hs ? 1'b0 : rd_done;
        rd_mask     = step_mask(tag_step[rd_sel]);
        issue_last  = (rd_cnt_cur == rd_mask);
        rd_addr     = tag_bitrev[rd_sel] ?
                      (rev_full(rd_cnt_cur) >> (MAX_STEP_L - tag_step[rd_sel])) : rd_cnt_cur;

        out_adv   = !m_valid || m_ready;
        p1_accept = !p1_valid || out_adv;
        issue     = p1_accept &&
                    ((bank_state[rd_sel] == BANK_FULL) ||
                     ((bank_state[rd_sel] == BANK_DRAINING) && !rd_done_cur));

        for (int b = 0; b < 2; b++) begin
            bank_state_next[b] = bank_state[b];
            if (wr_hs && (wr_bank == 1'(b)))
                bank_state_next[b] = wr_last ? BANK_FULL : BANK_FILLING;
            if (issue && (rd_sel == 1'(b)) && (bank_state[b] == BANK_FULL))
                bank_state_next[b] = BANK_DRAINING;
            if (m_last_hs && (rd_bank == 1'(b)))
                bank_state_next[b] = BANK_FREE;
        end

        // A bank freed by the reader becomes writable one edge after it is released
        if (wr_hs && wr_last)
            s_ready_next = (bank_state[~wr_bank] == BANK_FREE) ||
                           (bank_state[~wr_bank] == BANK_FILLING);
        else
            s_ready_next = (bank_state[wr_bank] == BANK_FREE) ||
                           (bank_state[wr_bank] == BANK_FILLING);
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= BANK_FREE;
                tag_step[b]   <= 4'd1;
                tag_bitrev[b] <= 1'b0;
            end
            s_ready  <= 1'b0;
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_bank  <= 1'b0;
            rd_cnt   <= '0;
            rd_done  <= 1'b0;
            p1_valid <= 1'b0;
            p1_last  <= 1'b0;
            p1_index <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_index  <= '0;
            m_real   <= '0;
            m_imag   <= '0;
        end else begin
            for (int b = 0; b < 2; b++)
                bank_state[b] <= bank_state_next[b];
            s_ready <= s_ready_next;

            if (wr_hs) begin
                if (bank_state[wr_bank] == BANK_FREE) begin
                    tag_step[wr_bank]   <= cfg_eff;
                    tag_bitrev[wr_bank] <= cfg_bitrev;
                end
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end

            rd_bank <= rd_sel;
            if (issue) begin
                rd_cnt  <= issue_last ? '0 : rd_cnt_cur + 1'b1;
                rd_done <= issue_last;
            end else begin
                rd_cnt  <= rd_cnt_cur;
                rd_done <= rd_done_cur;
            end

            // ram_q only reloads on issue, so it doubles as the hold stage under stall
            if (p1_accept) begin
                p1_valid <= issue;
                p1_last  <= issue_last;
                p1_index <= rd_addr;
            end

            if (out_adv) begin
                m_valid <= p1_valid;
                if (p1_valid) begin
                    m_real  <= ram_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    m_imag  <= ram_q[DATA_WIDTH-1:0];
                    m_last  <= p1_last;
                    m_index <= p1_index;
                end
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (wr_hs)
            mem[{wr_bank, wr_cnt}] <= {s_real, s_imag};
        if (issue)
            ram_q <= mem[{rd_sel, rd_addr}];
    end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// tb/tb_fft_frame_buffer.sv - directed self-checking bench for fft_frame_buffer
module tb_fft_frame_buffer;

    logic        iclk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  cfg_step = 4'd1;
    logic        cfg_bitrev = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_real = '0;
    logic [15:0] s_imag = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_real;
    logic [15:0] m_imag;
    logic        m_last;
    logic [8:0]  m_index;

    int errors = 0;
    int checks = 0;

    fft_frame_buffer #(.DATA_WIDTH(16), .MAX_STEP(9)) dut (
        .iclk       (iclk),
        .rstn       (rstn),
        .cfg_step   (cfg_step),
        .cfg_bitrev (cfg_bitrev),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_real     (s_real),
        .s_imag     (s_imag),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_real     (m_real),
        .m_imag     (m_imag),
        .m_last     (m_last),
        .m_index    (m_index)
    );

    always #5 iclk = ~iclk;

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    function automatic int rev_bits(input int k, input int nbits);
        int r = 0;
        for (int i = 0; i < nbits; i++)
            r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    // Pushes n samples base..base+n-1; cfg switches to mid_* after the first handshake
    task automatic push_frame(input int base, input int n, input int step, input int bitrev,
                              input int mid_step, input int mid_bitrev);
        int i = 0;
        int budget = 0;
        logic r;
        cfg_step   = 4'(step);
        cfg_bitrev = 1'(bitrev);
        while (i < n && budget < 4000) begin
            s_valid = 1'b1;
            s_real  = 16'(base + i);
            s_imag  = ~16'(base + i);
            r = s_ready;
            tick();
            budget++;
            if (r) begin
                i++;
                if (i == 1) begin
                    cfg_step   = 4'(mid_step);
                    cfg_bitrev = 1'(mid_bitrev);
                end
            end
        end
        s_valid = 1'b0;
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL push_timeout base=%0d got %0d of %0d samples", base, i, n);
        end
    endtask

    task automatic pull_frame(input int base, input int n, input int step, input int bitrev,
                              input int rnd);
        int k = 0;
        int budget = 0;
        int addr;
        logic        stalled = 1'b0;
        logic [15:0] h_real, h_imag;
        logic [8:0]  h_index;
        logic        h_last;
        while (k < n && budget < 4 * n + 100) begin
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1 || m_real !== h_real || m_imag !== h_imag ||
                    m_index !== h_index || m_last !== h_last) begin
                    errors++;
                    $display("FAIL hold_stable k=%0d got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b",
                             k, m_valid, m_real, m_index, m_last, h_real, h_index, h_last);
                end
            end
            m_ready = rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (m_valid && m_ready) begin
                addr = bitrev != 0 ? rev_bits(k, step) : k;
                checks++;
                if (m_real !== 16'(base + addr) || m_imag !== ~16'(base + addr)) begin
                    errors++;
                    $display("FAIL data k=%0d got re=%0d im=%0d want re=%0d", k, m_real, m_imag,
                             base + addr);
                end
                checks++;
                if (m_index !== 9'(addr)) begin
                    errors++;
                    $display("FAIL index k=%0d got %0d want %0d", k, m_index, addr);
                end
                checks++;
                if (m_last !== (k == n - 1)) begin
                    errors++;
                    $display("FAIL last k=%0d got %b want %b", k, m_last, k == n - 1);
                end
                k++;
            end else if (m_valid) begin
                stalled = 1'b1;
                h_real  = m_real;
                h_imag  = m_imag;
                h_index = m_index;
                h_last  = m_last;
            end
            tick();
            budget++;
        end
        m_ready = 1'b0;
        if (k < n) begin
            checks++;
            errors++;
            $display("FAIL pull_timeout base=%0d got %0d of %0d samples", base, k, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
            m_real !== 16'd0 || m_imag !== 16'd0 || m_index !== 9'd0) begin
            errors++;
            $display("FAIL %s got rdy=%b v=%b l=%b re=%0d im=%0d i=%0d want all 0", tag, s_ready,
                     m_valid, m_last, m_real, m_imag, m_index);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        check_reset_outputs("reset_values");
        tick();
        rstn = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL s_ready_before_edge got %b want 0", s_ready);
        end
        tick();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL s_ready_after_edge got %b want 1", s_ready);
        end
    endtask

    task automatic test_natural();
        m_ready = 1'b1;
        push_frame(0, 64, 6, 0, 6, 0);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_t1 got m_valid=%b want 0", m_valid);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_t2 got m_valid=%b want 0", m_valid);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_t3 got m_valid=%b want 1", m_valid);
        end
        pull_frame(0, 64, 6, 0, 0);
    endtask

    task automatic test_bitrev();
        logic [15:0] want [8] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
        int k = 0;
        int budget = 0;
        m_ready = 1'b0;
        push_frame(0, 8, 3, 1, 3, 1);
        m_ready = 1'b1;
        while (k < 8 && budget < 50) begin
            if (m_valid) begin
                checks++;
                if (m_real !== want[k] || m_index !== 9'(want[k]) || m_last !== (k == 7)) begin
                    errors++;
                    $display("FAIL bitrev_seq k=%0d got d=%0d i=%0d l=%b want d=%0d l=%b", k,
                             m_real, m_index, m_last, want[k], k == 7);
                end
                k++;
            end
            tick();
            budget++;
        end
        m_ready = 1'b0;
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL bitrev_count got %0d want 8", k);
        end
    endtask

    task automatic test_back_pressure();
        m_ready = 1'b0;
        push_frame(0, 16, 4, 0, 4, 0);
        pull_frame(0, 16, 4, 0, 1);
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b0;
        push_frame(0, 16, 4, 0, 4, 0);
        push_frame(16, 16, 4, 0, 4, 0);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL s_ready_full got %b want 0", s_ready);
        end
        fork
            push_frame(32, 16, 4, 0, 4, 0);
            begin
                pull_frame(0, 16, 4, 0, 0);
                m_ready = 1'b1;
                checks++;
                if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_cycle got m_valid=%b s_ready=%b want 0 0", m_valid, s_ready);
                end
                tick();
                checks++;
                if (m_valid !== 1'b1 || s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL after_gap got m_valid=%b s_ready=%b want 1 1", m_valid, s_ready);
                end
                pull_frame(16, 16, 4, 0, 0);
                pull_frame(32, 16, 4, 0, 0);
            end
        join
    endtask

    task automatic test_reconfig();
        m_ready = 1'b0;
        push_frame(200, 4, 2, 0, 3, 1);
        push_frame(300, 8, 3, 1, 3, 1);
        pull_frame(200, 4, 2, 0, 0);
        pull_frame(300, 8, 3, 1, 0);
    endtask

    task automatic test_clamp();
        m_ready = 1'b0;
        push_frame(0, 512, 12, 0, 12, 0);
        pull_frame(0, 512, 9, 0, 0);
        push_frame(40, 2, 0, 0, 0, 0);
        pull_frame(40, 2, 1, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        m_ready = 1'b0;
        push_frame(0, 20, 6, 0, 6, 0);
        rstn = 1'b0;
        #2;
        check_reset_outputs("mid_reset_values");
        tick();
        tick();
        rstn = 1'b1;
        tick();
        push_frame(100, 64, 6, 0, 6, 0);
        pull_frame(100, 64, 6, 0, 0);
        tick();
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_stale_data got m_valid=%b want 0", m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_bitrev();
        test_back_pressure();
        test_back_to_back();
        test_reconfig();
        test_clamp();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Parametrised ping-pong frame buffer placed in front of or behind the FFT_IFFT core. It collects complex samples from a ready/valid stream into frames of runtime-selectable length 2^cfg_step and replays each frame in natural or bit-reversed order with frame delimiting. It also replaces ad-hoc index/enable frame generation with a back-pressured, double-buffered source.

## Interface
- DATA_WIDTH, 16, bit width of each real/imag component
- MAX_STEP, 9, log2 of maximum frame length; each bank holds 2^MAX_STEP entries
- iclk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- cfg_step  in  4  log2 frame length; sampled at the first write of each frame
- cfg_bitrev  in  1  1 = read in bit-reversed order; sampled with cfg_step
- s_valid  in  1  input sample valid
- s_ready  out  1  buffer can accept a sample
- s_real, s_imag  in  DATA_WIDTH  input sample
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts
- m_real, m_imag  out  DATA_WIDTH  output sample
- m_last  out  1  final sample of frame, qualified by m_valid
- m_index  out  MAX_STEP  natural-order index of the presented sample

## Operation
- Two banks, each with a state: FREE, FILLING, FULL or DRAINING. After reset, both banks are FREE. Write pointer and read pointer both start at bank 0.
- Write side:
  - s_ready = 1 when the write bank is FREE or FILLING.
  - A handshake (s_valid & s_ready) stores the sample at wr_cnt and increments wr_cnt.
  - The first handshake of a frame latches cfg_step and cfg_bitrev into the bank's tag and moves the bank FREE→FILLING.
  - The handshake at wr_cnt = N-1 moves the bank FILLING→FULL, clears wr_cnt and toggles the write bank.
- Clamping of cfg_step: 0 is treated as 1; values above MAX_STEP are treated as MAX_STEP. N = 2^step_eff.
- Read side:
  - When the read bank is FULL, it moves to DRAINING.
  - rd_cnt runs 0..N-1. The RAM address is rd_cnt, or rd_cnt bit-reversed over step_eff bits when the tag's bitrev bit is set.
  - m_index = RAM address.
  - m_last = (rd_cnt = N-1).
  - The m_last handshake moves the bank DRAINING→FREE and toggles the read bank.
- Back-pressure: while m_valid & !m_ready, m_real/m_imag/m_last/m_index hold stable and no sample is lost or repeated.
- Each frame uses its own latched tag. cfg changes mid-frame have no effect until the next frame starts.
- Simultaneous events: a bank-free (read) and a bank-fill (write) on the same edge are both honoured, because the two banks differ. When both banks are FULL or DRAINING, s_ready = 0.
- Reset mid-operation discards all buffered data; banks return to FREE and counters to 0.

## Timing
- Reset values:
  - s_ready = 0; it rises on the first iclk edge after rstn deasserts.
  - m_valid = 0, m_last = 0, m_real = 0, m_imag = 0, m_index = 0.
- Synchronous single-port-read RAM, with a registered output stage that includes hold/skid for back-pressure.
- Latency: if the last write handshake occurs at edge T and the read side is idle, m_valid is first high after edge T+2.
- Sustained throughput is 1 sample/cycle per side.
- Between frames, m_valid is low for exactly one cycle after the m_last handshake, even when the next bank is already FULL.
- s_ready updates registered:
  - It falls on the edge of the handshake that fills the second bank.
  - It rises on the edge after the m_last handshake that frees a bank.

## Test plan
- Natural order: step=6, bitrev=0, input values 0..63 back-to-back, m_ready=1. The bench requires:
  - outputs 0..63 and m_index 0..63;
  - m_last high only at 63;
  - first m_valid 2 cycles after the last input.
- Bit-reversed order: step=3, bitrev=1, input values 0..7. Output must be 0,4,2,6,1,5,3,7, with m_index equal to the data and m_last on 7.
- Back-pressure: step=4, bitrev=0, m_ready toggled pseudo-randomly at 50%. Output must be exactly 0..15 in order, with data held stable while stalled.
- Double buffering: three 16-sample frames (0..15, 16..31, 32..47) pushed with m_ready=0. The bench requires:
  - s_ready drops after the 32nd sample;
  - after m_ready=1, frames drain in order with a 1-cycle gap between frames;
  - s_ready returns after the first m_last.
- Runtime reconfiguration and clamping:
  - Frame A with step=2, bitrev=0, then frame B with step=3, bitrev=1, where cfg changes during frame A's fill. Frame A must be 4 natural samples and frame B 8 bit-reversed samples.
  - step=12 with MAX_STEP=9 must produce 512-sample frames.
- Reset mid-frame: assert rstn low after 20 of 64 samples, then release. The bench requires:
  - all outputs at reset values;
  - a new 64-sample frame 100..163 drains as exactly 100..163 with no stale data.
